// File: rtl/add_4bit_serial_pkg.sv
// Shared types and constants for the bit-serial 4-bit adder.
package add4_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } add4_state_t;

   localparam logic [3:0] SAT_POS = 4'b0111;
   localparam logic [3:0] SAT_NEG = 4'b1000;

   // Clamp a wrapped result; the sign of the overflow follows the addend MSB.
   function automatic logic [3:0] sat_sum(input logic [3:0] raw, input logic ovf, input logic a_msb);
      logic [3:0] res;
      res = raw;
      if (ovf) begin
         res = a_msb ? SAT_NEG : SAT_POS;
      end else begin
         res = raw;
      end
      return res;
   endfunction

endpackage

// File: rtl/add_4bit_serial_fa_cell.sv
// 1-bit full adder cell, shared by the serial add and subtract datapaths.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_4bit_serial.sv
// Bit-serial two's-complement adder, LSB first, one full-adder cell.
// Optional saturation on signed overflow: define ADD4_SERIAL_SAT_EN.
module add_4bit_serial
   import add4_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int              CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   add4_state_t      state;
   add4_state_t      state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             carry_out_q;
   logic             overflow_q;
   logic             fa_s;
   logic             fa_co;
   logic             accept;
   logic             last_bit;
   logic             carry_into_msb;
   logic             ovf_fin;
   logic [WIDTH-1:0] sum_fin;
   logic [WIDTH-1:0] sum_done;

   fa_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = ADD;
               accept    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         ADD: begin
            if (cnt == LAST) begin
               state_nxt = DONE;
               last_bit  = 1'b1;
            end else begin
               state_nxt = ADD;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // In the last cycle the carry register still holds the carry into the MSB.
   assign carry_into_msb = carry;
   assign ovf_fin        = carry_into_msb ^ fa_co;
   assign sum_fin        = {fa_s, sum_sh[WIDTH-1:1]};

`ifdef ADD4_SERIAL_SAT_EN
   assign sum_done = sat_sum(sum_fin, ovf_fin, a_sh[0]);
`else
   assign sum_done = sum_fin;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh        <= '0;
         b_sh        <= '0;
         sum_sh      <= '0;
         cnt         <= '0;
         carry       <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         carry  <= cin;
         cnt    <= '0;
         sum_sh <= '0;
      end else if (state == ADD) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= fa_co;
         cnt   <= cnt + CNT_W'(1);
         if (last_bit) begin
            sum_sh      <= sum_done;
            carry_out_q <= fa_co;
            overflow_q  <= ovf_fin;
         end else begin
            sum_sh <= sum_fin;
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_sh;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_add_4bit_serial.sv
// Directed self-checking bench for add_4bit_serial (both ADD4_SERIAL_SAT_EN builds).
module tb_add_4bit_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] sum;
   logic       carry_out;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   add_4bit_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference result {overflow, carry_out, sum} from integer arithmetic.
   function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic c);
      int         sx, sy, ss, us;
      logic [3:0] s;
      logic       ov, co;
      sx = $signed(x);
      sy = $signed(y);
      ss = sx + sy + int'(c);
      us = int'(x) + int'(y) + int'(c);
      ov = (ss > 7) || (ss < -8);
      co = us[4];
      s  = us[3:0];
`ifdef ADD4_SERIAL_SAT_EN
      if (ov) s = (ss > 7) ? 4'b0111 : 4'b1000;
`endif
      return {ov, co, s};
   endfunction

   // One operation; stall holds out_ready low for that many cycles after out_valid.
   task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y, input logic c,
                         input logic [3:0] es, input logic eco, input logic eov, input int stall);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      a = x; b = y; cin = c; in_valid = 1'b1;
      out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0;
      a = ~x; b = ~y; cin = ~c;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, 4);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, carry_out, eco);
      check({tag, "_ovf"}, overflow, eov);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, "_hold"}, {in_ready, out_valid, overflow, carry_out, sum}, {1'b0, 1'b1, eov, eco, es});
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_pop"}, {out_valid, in_ready}, 2'b01);
   endtask

   logic [3:0] va [16];
   logic [3:0] vb [16];
   logic       vc [16];

   initial begin
      int acc, res, last, n;
      logic pend;
      logic [5:0] e;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = 4'd0; b = 4'd0; cin = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_outs", {in_ready, out_valid, overflow, carry_out, sum}, 8'b1000_0000);

      run_op("add_3_4", 4'd3, 4'd4, 1'b0, 4'b0111, 1'b0, 1'b0, 0);
`ifdef ADD4_SERIAL_SAT_EN
      run_op("add_7_1", 4'd7, 4'd1, 1'b0, 4'b0111, 1'b0, 1'b1, 0);
      run_op("add_m8_m1", 4'b1000, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 0);
      run_op("add_5_2_c", 4'd5, 4'd2, 1'b1, 4'b0111, 1'b0, 1'b1, 0);
`else
      run_op("add_7_1", 4'd7, 4'd1, 1'b0, 4'b1000, 1'b0, 1'b1, 0);
      run_op("add_m8_m1", 4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1, 1'b1, 0);
      run_op("add_5_2_c", 4'd5, 4'd2, 1'b1, 4'b1000, 1'b0, 1'b1, 0);
`endif
      run_op("add_m1_1", 4'b1111, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 0);
      run_op("bp_6_m3", 4'd6, 4'b1101, 1'b0, 4'd3, 1'b1, 1'b0, 10);

      // Abort an operation with the counter at 2.
      @(negedge clk);
      a = 4'd6; b = 4'd5; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_outs", {in_ready, out_valid, overflow, carry_out, sum}, 8'b1000_0000);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      check("rst_mid_no_valid", n, 0);
      run_op("add_2_2", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 0);

      // Back-to-back stream with both handshakes held high.
      for (int i = 0; i < 16; i++) begin
         va[i] = 4'($urandom_range(15, 0));
         vb[i] = 4'($urandom_range(15, 0));
         vc[i] = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      out_ready = 1'b1;
      a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
      acc = 0; res = 0; last = 0; pend = 1'b0;
      for (int c = 0; c < 200 && res < 16; c++) begin
         if (c > 0) @(negedge clk);
         if (pend) begin
            pend = 1'b0;
            if (acc < 16) begin
               a = va[acc]; b = vb[acc]; cin = vc[acc];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            e = model(va[res], vb[res], vc[res]);
            check("stream_result", {overflow, carry_out, sum}, e);
            res++;
         end
         if (in_ready && in_valid) begin
            if (acc > 0) check("stream_gap", c - last, 6);
            last = c;
            acc++;
            pend = 1'b1;
         end
      end
      check("stream_count", res, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
